// File: rtl/key_entry_controller.sv
// key_entry_controller: collects a CODE_LEN-symbol PIN from the keypad link,
// compares it against CODE_IN and reports OK/ERROR to the main FSM.
// Consecutive wrong codes are counted and trigger a timed lockout.
//
// Handshake: KEY_STATUS is a held status, not a pulse. Once it leaves NO_KEY
// (2'b11) it stays at OK (2'b00) or ERROR (2'b10) until KEY_ACK is sampled
// high in REPORT. It returns to NO_KEY on the following cycle. KEY_ACK is
// ignored in every other state.
module key_entry_controller #(
    parameter int CODE_LEN    = 4,
    parameter int TIMEOUT_CYC = 5000,
    parameter int MAX_FAILS   = 3,
    parameter int LOCKOUT_CYC = 30000,
    parameter int CNT_W       = 18
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [1:0]            KB_IN,
    input  logic                  KB_RECV,
    input  logic [2*CODE_LEN-1:0] CODE_IN,
    input  logic                  KEY_ACK,
    output logic [1:0]            KEY_STATUS,
    output logic                  BUSY,
    output logic                  LOCKED,
    output logic [1:0]            FAIL_CNT,
    output logic [1:0]            DBG_STATE
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_REPORT  = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    localparam int              IDX_W    = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CODE_LEN - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] LO_LAST  = CNT_W'(LOCKOUT_CYC - 1);
    localparam logic [1:0]       FAIL_MAX = 2'(MAX_FAILS);
    localparam logic [1:0]       ST_OK    = 2'b00;
    localparam logic [1:0]       ST_ERR   = 2'b10;
    localparam logic [1:0]       ST_NONE  = 2'b11;

    // Synchronizer and edge-detector flops
    logic [1:0] kb_in_s1_q, kb_in_s2_q;
    logic       kb_recv_s1_q, kb_recv_s2_q, kb_recv_d_q;
    logic       sym_evt;

    // FSM state and datapath registers
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             mism_q, mism_d;
    logic [1:0]       status_q, status_d;
    logic [1:0]       fail_q, fail_d;

    logic [1:0] exp_sym;
    logic       mism_any;
    logic [1:0] fail_inc;

    // Two-flop synchronizers on the keypad pins plus a delay flop for edge detect
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            kb_in_s1_q   <= 2'b00;
            kb_in_s2_q   <= 2'b00;
            kb_recv_s1_q <= 1'b0;
            kb_recv_s2_q <= 1'b0;
            kb_recv_d_q  <= 1'b0;
        end else begin
            kb_in_s1_q   <= KB_IN;
            kb_in_s2_q   <= kb_in_s1_q;
            kb_recv_s1_q <= KB_RECV;
            kb_recv_s2_q <= kb_recv_s1_q;
            kb_recv_d_q  <= kb_recv_s2_q;
        end
    end

    // A symbol is the synced strobe rising; a held-high strobe yields one event
    assign sym_evt = kb_recv_s2_q & ~kb_recv_d_q;

    // Select the reference symbol for the current index; symbol 0 sits in the MSBs
    always_comb begin
        exp_sym = 2'b00;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (idx_q == IDX_W'(i)) begin
                exp_sym = CODE_IN[2*(CODE_LEN-1-i) +: 2];
            end
        end
    end

    assign mism_any = mism_q | (kb_in_s2_q != exp_sym);
    assign fail_inc = (fail_q < FAIL_MAX) ? fail_q + 2'd1 : fail_q;

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            mism_q   <= 1'b0;
            status_q <= ST_NONE;
            fail_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            mism_q   <= mism_d;
            status_q <= status_d;
            fail_q   <= fail_d;
        end
    end

    // Next-state logic: capture, timeout, report handshake and lockout timer
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        mism_d   = mism_q;
        status_d = status_q;
        fail_d   = fail_q;

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (sym_evt) begin
                    // A capture on the timeout cycle wins over the timeout
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d  = S_REPORT;
                        status_d = mism_any ? ST_ERR : ST_OK;
                        idx_d    = '0;
                        mism_d   = 1'b0;
                    end else begin
                        state_d = S_COLLECT;
                        idx_d   = idx_q + IDX_W'(1);
                        mism_d  = mism_any;
                    end
                end else if (state_q == S_COLLECT) begin
                    if (cnt_q == TO_LAST) begin
                        // Abandoned entry: discard silently, failures untouched
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        idx_d   = '0;
                        mism_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_REPORT: begin
                if (KEY_ACK) begin
                    status_d = ST_NONE;
                    if (status_q == ST_OK) begin
                        fail_d  = 2'd0;
                        state_d = S_IDLE;
                    end else begin
                        fail_d = fail_inc;
                        cnt_d  = '0;
                        state_d = (fail_inc == FAIL_MAX) ? S_LOCKOUT : S_IDLE;
                    end
                end
            end
            S_LOCKOUT: begin
                if (cnt_q == LO_LAST) begin
                    fail_d  = 2'd0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign KEY_STATUS = status_q;
    assign BUSY       = (state_q == S_COLLECT);
    assign LOCKED     = (state_q == S_LOCKOUT);
    assign FAIL_CNT   = fail_q;
    assign DBG_STATE  = state_q;

endmodule

// File: doc/key_entry_controller.md
Name: key_entry_controller

Overview:
- Sequences PIN entry from the remote keypad link (KB_IN/KB_RECV) for the alarm main FSM.
- Collects CODE_LEN 2-bit symbols and compares them against the configured code.
- Reports OK/ERROR through a held-status/ack handshake.
- Counts consecutive failures and imposes a lockout after MAX_FAILS wrong codes. Sits between the keypad serial receiver pins and the main state machine.

Parameters:
- CODE_LEN, 4, number of symbols per code entry (2..8).
- TIMEOUT_CYC, 5000, maximum CLK cycles allowed between symbols inside an entry.
- MAX_FAILS, 3, consecutive ERROR reports that trigger lockout (1..3).
- LOCKOUT_CYC, 30000, lockout duration in CLK cycles.
- CNT_W, 18, width of the shared cycle counter. Must hold max(TIMEOUT_CYC, LOCKOUT_CYC).

Ports:
- CLK, input, 1, system clock (LSOSC-derived).
- RST, input, 1, asynchronous active-low reset.
- KB_IN, input, 2, keypad symbol data; asynchronous to CLK.
- KB_RECV, input, 1, keypad symbol strobe; asynchronous to CLK; a rising edge marks a symbol.
- CODE_IN, input, 2*CODE_LEN, reference code. The first symbol occupies the MSBs.
- KEY_ACK, input, 1, main FSM acknowledge of KEY_STATUS.
- KEY_STATUS, output, 2, 2'b00 = OK, 2'b10 = ERROR, 2'b11 = NO_KEY.
- BUSY, output, 1, high while an entry is in progress (COLLECT).
- LOCKED, output, 1, high during lockout.
- FAIL_CNT, output, 2, consecutive failure count.

Behaviour:
- Reset (RST=0, asynchronous):
  - State = IDLE; KEY_STATUS = 2'b11; BUSY = 0; LOCKED = 0; FAIL_CNT = 0.
  - Counter, symbol index, mismatch flag and synchronizers = 0.
  - Reset mid-entry or mid-lockout discards everything.
- Input capture:
  - KB_IN and KB_RECV each pass through a 2-flop synchronizer.
  - A symbol event is synced KB_RECV going 0->1 (edge detector). The synced KB_IN is captured on that cycle.
  - Pin-to-capture latency is 3 CLK cycles. KB_IN must be stable 3 cycles around the KB_RECV edge.
- Comparison:
  - Symbol i (0-based) is compared with CODE_IN[2*(CODE_LEN-1-i)+1 : 2*(CODE_LEN-1-i)], using live CODE_IN at capture time.
  - Any mismatch sets a sticky mismatch flag. Entry length is always CODE_LEN symbols; there is no early abort on mismatch.
- States:
  - IDLE: KEY_STATUS = 11. A symbol event captures symbol 0, clears the counter and goes to COLLECT. If CODE_LEN = 1, it goes directly to REPORT.
  - COLLECT: BUSY = 1. The counter increments every cycle and clears on each symbol event.
    - On capture of symbol CODE_LEN-1 -> REPORT. KEY_STATUS is valid the next cycle: 00 if no mismatch, else 10.
    - If the counter reaches TIMEOUT_CYC-1 with no event that cycle -> IDLE. The entry is discarded, no report is made and FAIL_CNT is unchanged.
    - A symbol event on the timeout cycle wins and is counted.
  - REPORT: KEY_STATUS is held until KEY_ACK=1 is sampled. Symbol events are ignored (dropped, not queued). On ACK:
    - OK: FAIL_CNT <= 0 -> IDLE.
    - ERROR: FAIL_CNT <= FAIL_CNT+1. If the new value equals MAX_FAILS -> LOCKOUT, else -> IDLE.
    - KEY_STATUS returns to 11 on the cycle after ACK.
  - LOCKOUT: LOCKED = 1; KEY_STATUS = 11; symbol events ignored. The counter runs from 0. At LOCKOUT_CYC-1: FAIL_CNT <= 0, LOCKED <= 0 -> IDLE.
- Edge cases:
  - KEY_ACK outside REPORT is ignored.
  - A KB_RECV level held high produces only one event.
  - FAIL_CNT saturates at MAX_FAILS.
  - The counter never wraps, because of the CNT_W constraint.

Test Plan:
- Reset, CODE_IN=8'h1B, send symbols 0,1,2,3 -> BUSY high from the first capture; KEY_STATUS=00 one cycle after the 4th capture; held until KEY_ACK; then 11, FAIL_CNT=0.
- CODE_IN=8'h1B, send 0,1,3,3, ack -> KEY_STATUS=10, FAIL_CNT=1, state IDLE. Repeat twice -> after the third ack LOCKED=1 and FAIL_CNT=3.
- During lockout, send 4 valid symbols -> ignored, KEY_STATUS stays 11. After LOCKOUT_CYC cycles -> LOCKED=0, FAIL_CNT=0. A correct code is then accepted with 00.
- Send 2 symbols, then idle TIMEOUT_CYC cycles -> BUSY falls, no report, FAIL_CNT unchanged. The next full correct entry gives 00.
- Edge cases:
  - Symbol event exactly on the timeout cycle -> counted, entry continues.
  - Strobe during REPORT before ack -> dropped.
  - KEY_ACK asserted in IDLE -> no effect.
- Assert RST low mid-COLLECT and mid-LOCKOUT -> all outputs at reset values immediately (asynchronous). After release, the first correct entry gives 00.
